fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch and next-PC sequencer for the MIPS CPU.
- Owns the PC and requests instruction words from instruction memory over a req/ack handshake.
- Presents the decoded field slices (opcode, funct, rs, rt, rd, shamt, imm, target) to the control decoder and register file.
- Consumes the decoder's Branch/BNE/Jump outputs plus the ALU zero flag to select the next PC.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- ADDR_W, 32, PC and imem address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request, held high until ack.
- imem_addr  out  ADDR_W  word-aligned fetch address (equals pc).
- imem_ack  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  instruction word.
- instr_valid  out  1  instruction fields valid for decode/execute.
- opcode  out  6  instr[31:26].
- funct  out  6  instr[5:0].
- rs, rt, rd  out  5 each  instr[25:21], [20:16], [15:11].
- shamt  out  5  instr[10:6].
- imm  out  16  instr[15:0].
- pc  out  ADDR_W  address of the current instruction.
- pc_plus4  out  ADDR_W  pc + 4.
- stall  in  1  datapath hold; keeps the instruction in EXEC.
- Branch  in  1  from decoder, conditional branch.
- BNE  in  1  from decoder, branch sense inverted.
- Jump  in  1  from decoder, j-type jump.
- zero  in  1  ALU zero flag.

Behaviour:
- Reset (synchronous, active-high; rst wins over every other input, including mid-FETCH with an ack arriving in the same cycle):
  - State goes to BOOT, pc = PC_RESET.
  - Instruction register = 32'h0000_0000.
  - imem_req = 0, instr_valid = 0.
- FSM states:
  - BOOT: one idle cycle; next state FETCH.
  - FETCH: imem_req = 1, imem_addr = pc.
    - On imem_ack: latch imem_rdata into the instruction register, go to EXEC.
    - Without ack: stay in FETCH; imem_addr stays stable.
  - EXEC: instr_valid = 1, field outputs are combinational slices of the instruction register. Decoder and ALU respond combinationally in the same cycle.
    - If stall = 1: remain in EXEC; pc is unchanged.
    - Else: pc <= next_pc, go to FETCH.
- Fetch latency: minimum 2 cycles per instruction (FETCH with same-cycle ack, then EXEC).
- imem_ack outside FETCH is ignored.
- next_pc, priority order:
  1. Jump = 1: {pc_plus4[31:28], instr[25:0], 2'b00}.
  2. Else Branch = 1 and (zero XOR BNE) = 1: pc_plus4 + ({{14{imm[15]}}, imm, 2'b00}).
  3. Else: pc_plus4.
  - Jump and Branch both 1: Jump wins.
- Arithmetic: 32-bit modulo; pc_plus4 wraps 32'hFFFF_FFFC to 32'h0000_0000. Negative offsets are sign-extended. pc[1:0] is always 0.
- Outside EXEC the field outputs hold the last instruction, but instr_valid = 0. Downstream writes are qualified by instr_valid.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs retired_cnt[31:0] and taken_cnt[31:0], both reset to 0.
  - retired_cnt increments on each EXEC cycle with stall = 0.
  - taken_cnt increments when such a cycle selects the Jump or taken-Branch path.
  - Both counters wrap at 2^32.
- Undefined: ports and counters are absent; core behaviour is identical.

Test Plan:
- Reset, ack always 1, imem returns NOPs -> imem_addr sequence 0x0, 0x4, 0x8, each EXEC 2 cycles apart; instr_valid is 0 in BOOT and FETCH.
- At pc = 0x100: beq with imm = 16'hFFFE, Branch = 1, zero = 1 -> next fetch at 0x0FC. Same case with zero = 0 -> 0x104.
- bne: Branch = 1, BNE = 1, zero = 0, imm = 0x0003 at pc = 0x20 -> next 0x30. With zero = 1 -> next 0x24.
- j with target 26'h0000040 at pc = 0x8000_0010, Jump = 1 with Branch = 1 also asserted -> next 0x8000_0100.
- imem_ack delayed 3 cycles, then stall held 2 cycles in EXEC -> imem_req and imem_addr stable throughout; pc unchanged while stalled; the stray ack during EXEC is ignored.
- rst asserted in FETCH in the same cycle as imem_ack -> pc = PC_RESET, state BOOT, instruction not latched. With FETCH_PERF_CNT_EN: counters read 0 after reset and 3/1 after three instructions with one taken branch.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch and next-PC sequencer: owns the PC, fetches over a req/ack
// handshake and slices the instruction word. Optional counters: FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] PC_RESET = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    output logic [5:0]        opcode,
    output logic [5:0]        funct,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [15:0]       imm,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]       retired_cnt,
    output logic [31:0]       taken_cnt,
`endif
    input  logic              stall,
    input  logic              Branch,
    input  logic              BNE,
    input  logic              Jump,
    input  logic              zero
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ADDR_W-1:0]   pc_r;
    logic [31:0]         instr_r;
    logic [ADDR_W-1:0]   pc_plus4_s;
    logic [ADDR_W-1:0]   next_pc_s;
    logic                taken_s;
    logic                exec_adv_s;
    logic                fetch_done_s;
    logic                imem_req_s;
    logic                instr_valid_s;

    // Redirect target: jump beats branch; offsets are sign-extended word counts.
    function automatic logic [ADDR_W-1:0] calc_next_pc(
        input logic [ADDR_W-1:0] seq_pc,
        input logic [31:0]       instr,
        input logic              jump_sel,
        input logic              branch_sel
    );
        logic [ADDR_W-1:0] target;
        if (jump_sel) begin
            target = {seq_pc[ADDR_W-1:28], instr[25:0], 2'b00};
        end else if (branch_sel) begin
            target = seq_pc + {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
        end else begin
            target = seq_pc;
        end
        return target;
    endfunction

    // Sequential PC, redirect decision and handshake qualifiers.
    always_comb begin
        pc_plus4_s   = pc_r + {{(ADDR_W-3){1'b0}}, 3'd4};
        taken_s      = Jump | (Branch & (zero ^ BNE));
        next_pc_s    = calc_next_pc(pc_plus4_s, instr_r, Jump, Branch & (zero ^ BNE));
        exec_adv_s   = (state_r == ST_EXEC) & ~stall;
        fetch_done_s = (state_r == ST_FETCH) & imem_ack;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_BOOT: begin
                state_nxt_s = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (stall) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            default: begin
                state_nxt_s = ST_BOOT;
            end
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        imem_req_s    = 1'b0;
        instr_valid_s = 1'b0;
        case (state_r)
            ST_BOOT: begin
                imem_req_s    = 1'b0;
                instr_valid_s = 1'b0;
            end
            ST_FETCH: begin
                imem_req_s    = 1'b1;
                instr_valid_s = 1'b0;
            end
            ST_EXEC: begin
                imem_req_s    = 1'b0;
                instr_valid_s = 1'b1;
            end
            default: begin
                imem_req_s    = 1'b0;
                instr_valid_s = 1'b0;
            end
        endcase
    end

    // PC and instruction register; reset overrides a same-cycle ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r    <= PC_RESET;
            instr_r <= 32'h0000_0000;
        end else begin
            if (exec_adv_s) begin
                pc_r <= next_pc_s;
            end else begin
                pc_r <= pc_r;
            end
            if (fetch_done_s) begin
                instr_r <= imem_rdata;
            end else begin
                instr_r <= instr_r;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] retired_cnt_r;
    logic [31:0] taken_cnt_r;

    // Retirement and redirect counters, free-running modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt_r <= 32'd0;
            taken_cnt_r   <= 32'd0;
        end else begin
            if (exec_adv_s) begin
                retired_cnt_r <= retired_cnt_r + 32'd1;
            end else begin
                retired_cnt_r <= retired_cnt_r;
            end
            if (exec_adv_s && taken_s) begin
                taken_cnt_r <= taken_cnt_r + 32'd1;
            end else begin
                taken_cnt_r <= taken_cnt_r;
            end
        end
    end

    assign retired_cnt = retired_cnt_r;
    assign taken_cnt   = taken_cnt_r;
`else
    logic unused_taken_s;
    assign unused_taken_s = taken_s;
`endif

    assign imem_req    = imem_req_s;
    assign imem_addr   = pc_r;
    assign instr_valid = instr_valid_s;
    assign pc          = pc_r;
    assign pc_plus4    = pc_plus4_s;
    assign opcode      = instr_r[31:26];
    assign rs          = instr_r[25:21];
    assign rt          = instr_r[20:16];
    assign rd          = instr_r[15:11];
    assign shamt       = instr_r[10:6];
    assign funct       = instr_r[5:0];
    assign imm         = instr_r[15:0];

endmodule
